// File: rtl/sfb_pkg.sv
// Shared types for the sample frame buffer: bank lifecycle and the writer/reader FSM states.
package sfb_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sfb_if.sv
// Sample-in and frame/read handshake bundle between the front end, the consumer and the buffer.
interface sfb_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              frame_valid;
    logic              frame_start;
    logic              frame_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output in_valid, in_data, frame_start, frame_done, rd_en, rd_addr,
        input  frame_valid, rd_data, rd_valid
    );

    modport slave (
        input  in_valid, in_data, frame_start, frame_done, rd_en, rd_addr,
        output frame_valid, rd_data, rd_valid
    );
endinterface

// File: rtl/sfb_bank_ram.sv
// Simple dual-port RAM holding both banks; registered read with enable so the output holds when idle.
module sfb_bank_ram #(
    parameter int DATA_W = 16,
    parameter int RAM_AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [RAM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Only the output register is reset; the array stays reset-free for block RAM inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong capture buffer: fills two banks alternately, hands full banks to a consumer,
// serves registered random-access reads and counts samples dropped while both banks are busy.
module sample_frame_buffer
    import sfb_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    parameter  int CNT_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             overflow_clr,
    sfb_if.slave             bus,
    output logic [ADDR_W:0]  wr_level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);
    wr_state_t         wr_state, wr_state_nxt;
    rd_state_t         rd_state, rd_state_nxt;
    logic              wr_bank, wr_bank_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    bank_state_t       bank_st [2];
    bank_state_t       bank_st_nxt [2];

    logic frame_valid;
    logic wr_fire, drop, start_fire, done_fire, rd_fire, last_wr, other_free;

    assign frame_valid     = (rd_state == R_IDLE) && (bank_st[rd_bank] == FULL);
    assign bus.frame_valid = frame_valid;
    assign wr_level        = (wr_state == W_FILL) ? {1'b0, wr_ptr} : '0;

    always_comb begin
        wr_fire    = !flush && (wr_state == W_FILL)  && bus.in_valid;
        drop       = !flush && (wr_state == W_STALL) && bus.in_valid;
        start_fire = !flush && frame_valid && bus.frame_start;
        done_fire  = !flush && (rd_state == R_BUSY) && bus.frame_done;
        rd_fire    = !flush && (rd_state == R_BUSY) && bus.rd_en;
        last_wr    = wr_fire && (wr_ptr == ADDR_W'(DEPTH - 1));
        // A bank released this very cycle counts as free, so fill completion never stalls on it.
        other_free = (bank_st[~wr_bank] == EMPTY) || (done_fire && (rd_bank != wr_bank));
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_bank_nxt  = wr_bank;
        wr_ptr_nxt   = wr_ptr;
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        bank_st_nxt  = bank_st;
        if (flush) begin
            wr_state_nxt   = W_FILL;
            wr_bank_nxt    = 1'b0;
            wr_ptr_nxt     = '0;
            rd_state_nxt   = R_IDLE;
            rd_bank_nxt    = 1'b0;
            bank_st_nxt[0] = EMPTY;
            bank_st_nxt[1] = EMPTY;
        end else begin
            case (wr_state)
                W_FILL: begin
                    if (wr_fire) begin
                        wr_ptr_nxt           = wr_ptr + ADDR_W'(1);
                        bank_st_nxt[wr_bank] = last_wr ? FULL : FILLING;
                        if (last_wr) begin
                            wr_bank_nxt = ~wr_bank;
                            if (!other_free)
                                wr_state_nxt = W_STALL;
                        end
                    end
                end
                W_STALL: begin
                    if (done_fire)
                        wr_state_nxt = W_FILL;
                end
                default: wr_state_nxt = W_FILL;
            endcase

            case (rd_state)
                R_IDLE: begin
                    if (start_fire) begin
                        bank_st_nxt[rd_bank] = READING;
                        rd_state_nxt         = R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (done_fire) begin
                        bank_st_nxt[rd_bank] = EMPTY;
                        rd_bank_nxt          = ~rd_bank;
                        rd_state_nxt         = R_IDLE;
                    end
                end
                default: rd_state_nxt = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= W_FILL;
            rd_state   <= R_IDLE;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            wr_state   <= wr_state_nxt;
            rd_state   <= rd_state_nxt;
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_ptr     <= wr_ptr_nxt;
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.rd_valid <= 1'b0;
        else
            bus.rd_valid <= rd_fire;
    end

    // A drop on the clearing cycle wins: the flag stays set and the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr)
                drop_count <= CNT_W'(1);
            else if (drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    sfb_bank_ram #(
        .DATA_W (DATA_W),
        .RAM_AW (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (bus.in_data),
        .re    (rd_fire),
        .raddr ({rd_bank, bus.rd_addr}),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer (DEPTH=8): reads are scoreboarded with data and latency,
// status outputs are checked inline against hand-computed values.
module tb_sample_frame_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       due;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             overflow_clr;
    logic [ADDR_W:0]  wr_level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    exp_t        q[$];

    sfb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sample_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .overflow_clr (overflow_clr),
        .bus          (bus),
        .wr_level     (wr_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: every rd_valid must match the oldest outstanding read, one cycle after issue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 data=%0h, required rd_valid=0", bus.rd_data);
            end else begin
                e = q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                check("rd_latency_cycle", cyc, e.due);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rd_missing: got rd_valid=0, required rd_valid=1 data=%0h", e.data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_done  = 1'b0;
        bus.rd_en       = 1'b0;
        flush           = 1'b0;
        overflow_clr    = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input int unsigned a, input logic [DATA_W-1:0] v);
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(a);
        q.push_back('{v, cyc + 1});
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.in_data = '0;
        bus.rd_addr = '0;
        clr_in();
        #1 rst_n = 1'b0;
        #2;
        check("rst_frame_valid", 32'(bus.frame_valid), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_wr_level", 32'(wr_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single frame, read back in order
        for (int i = 1; i <= 8; i++) begin
            check("t1_wr_level", 32'(wr_level), 32'(i - 1));
            feed(DATA_W'(i));
        end
        check("t1_frame_valid", 32'(bus.frame_valid), 1);
        check("t1_wr_level_after", 32'(wr_level), 0);
        start_frame();
        check("t1_frame_valid_claimed", 32'(bus.frame_valid), 0);
        for (int a = 0; a < 8; a++) begin
            rd(a, DATA_W'(a + 1));
            tick();
        end
        bus.rd_en      = 1'b0;
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        check("t1_frame_valid_done", 32'(bus.frame_valid), 0);

        // 2: flush back to bank0, stream 19 with no consumer
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            if (i == 17) begin
                check("t2_no_drop_yet", 32'(overflow), 0);
                check("t2_count_zero", 32'(drop_count), 0);
                check("t2_frame_valid", 32'(bus.frame_valid), 1);
            end
            feed(DATA_W'(i));
        end
        check("t2_overflow", 32'(overflow), 1);
        check("t2_drop_count", 32'(drop_count), 3);
        check("t2_wr_level_stall", 32'(wr_level), 0);

        // 3: free bank0; sample on freeing cycle dropped, next one lands at bank0 addr0
        start_frame();
        bus.frame_done = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'h00AA;
        tick();
        bus.frame_done = 1'b0;
        bus.in_data    = 16'h0BB0;
        tick();
        bus.in_valid = 1'b0;
        check("t3_drop_count", 32'(drop_count), 4);
        check("t3_wr_level", 32'(wr_level), 1);
        check("t3_frame_valid_bank1", 32'(bus.frame_valid), 1);
        start_frame();
        for (int a = 0; a < 8; a++) begin
            rd(a, DATA_W'(9 + a));
            bus.in_valid = (a < 7);
            bus.in_data  = DATA_W'(16'h0C01 + a);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        // done and start together while busy: done wins, bank0 then waits as a fresh frame
        bus.frame_done  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        clr_in();
        check("t3_done_wins", 32'(bus.frame_valid), 1);
        check("t3_no_new_drops", 32'(drop_count), 4);
        start_frame();
        rd(0, 16'h0BB0);
        tick();
        rd(3, 16'h0C03);
        tick();
        rd(7, 16'h0C07);
        bus.frame_done = 1'b1;
        tick();
        clr_in();
        check("t3_idle_no_frame", 32'(bus.frame_valid), 0);
        // inputs ignored while idle with no full bank
        bus.rd_en       = 1'b1;
        bus.rd_addr     = '0;
        bus.frame_done  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        clr_in();
        tick();
        check("t3_rd_data_hold", 32'(bus.rd_data), 32'h0C07);

        // 5: flush while busy with wr_ptr=5
        for (int i = 1; i <= 8; i++) feed(DATA_W'(16'h0D00 + i));
        check("t5_frame_valid", 32'(bus.frame_valid), 1);
        check("t5_wr_level_toggle", 32'(wr_level), 0);
        start_frame();
        for (int i = 1; i <= 5; i++) feed(DATA_W'(16'h0D10 + i));
        check("t5_wr_level5", 32'(wr_level), 5);
        rd(2, 16'h0D03);
        tick();
        flush        = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 3'd3;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        tick();
        clr_in();
        check("t5_flush_frame_valid", 32'(bus.frame_valid), 0);
        check("t5_flush_wr_level", 32'(wr_level), 0);
        check("t5_flush_rd_valid", 32'(bus.rd_valid), 0);
        check("t5_flush_keeps_overflow", 32'(overflow), 1);
        check("t5_flush_keeps_count", 32'(drop_count), 4);
        for (int i = 1; i <= 8; i++) feed(DATA_W'(16'h0E00 + i));
        check("t5_fresh_frame", 32'(bus.frame_valid), 1);
        start_frame();
        rd(0, 16'h0E01);
        tick();
        rd(7, 16'h0E08);
        tick();
        clr_in();

        // 4: clear racing a drop, then clear alone
        for (int i = 1; i <= 8; i++) feed(DATA_W'(16'h0E10 + i));
        check("t4_stall_level", 32'(wr_level), 0);
        bus.in_valid = 1'b1;
        overflow_clr = 1'b1;
        tick();
        clr_in();
        check("t4_set_wins_flag", 32'(overflow), 1);
        check("t4_set_wins_count", 32'(drop_count), 1);
        overflow_clr = 1'b1;
        tick();
        clr_in();
        check("t4_clr_flag", 32'(overflow), 0);
        check("t4_clr_count", 32'(drop_count), 0);
        feed(16'h0E99);
        check("t4_redrop_count", 32'(drop_count), 1);

        // 6: async reset mid-read
        rd(1, 16'h0E02);
        tick();
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 3'd5;
        bus.frame_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rd_valid", 32'(bus.rd_valid), 0);
        check("t6_rst_rd_data", 32'(bus.rd_data), 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        check("t6_rst_drop_count", 32'(drop_count), 0);
        check("t6_rst_frame_valid", 32'(bus.frame_valid), 0);
        check("t6_rst_wr_level", 32'(wr_level), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_idle_frame_valid", 32'(bus.frame_valid), 0);
        for (int i = 1; i <= 8; i++) feed(DATA_W'(16'h0F00 + i));
        check("t6_new_frame", 32'(bus.frame_valid), 1);
        check("t6_rd_data_still0", 32'(bus.rd_data), 0);
        clr_in();
        start_frame();
        rd(4, 16'h0F05);
        tick();
        clr_in();
        bus.frame_done = 1'b1;
        tick();
        clr_in();
        tick();
        tick();
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
